// File: rtl/if_fetch_ctrl_if.sv
// Bus bundle for the fetch sequencer: redirect, ID handshake and instruction SRAM.
// slave is the controller's view, master is the environment's view.
interface if_fetch_ctrl_if;
    logic        br_valid;
    logic [31:0] br_target;
    logic        id_allowin;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    modport slave (
        input  br_valid, br_target, id_allowin, inst_sram_rdata,
        output inst_sram_en, inst_sram_addr, if_valid, if_pc, if_inst
    );

    modport master (
        output br_valid, br_target, id_allowin, inst_sram_rdata,
        input  inst_sram_en, inst_sram_addr, if_valid, if_pc, if_inst
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer: one SRAM read per cycle, one read in flight,
// and a 2-deep (out + skid) FIFO holding stage toward ID.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    if_fetch_ctrl_if.slave  bus
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        out_v_q, out_v_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;

    logic        out_free;
    logic        out_held;
    logic        sram_en;
    logic [31:0] sram_addr;

    assign out_held  = out_v_q && !bus.id_allowin;
    assign out_free  = !out_held;
    assign sram_addr = bus.br_valid ? bus.br_target : fetch_pc_q;

    // Throttle so that a held out reg can always absorb the in-flight read in skid.
    assign sram_en = !rst_i &&
                     (bus.br_valid || (!skid_v_q && !(pend_q && out_held)));

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        pend_d      = 1'b0;
        pend_pc_d   = pend_pc_q;
        out_v_d     = out_v_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        skid_v_d    = skid_v_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;

        // A redirect flushes the holding stage and the response arriving this
        // cycle at the same edge, so no separate squash state is needed.
        if (bus.br_valid) begin
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
        end else if (out_free) begin
            if (skid_v_q) begin
                out_v_d    = 1'b1;
                out_pc_d   = skid_pc_q;
                out_inst_d = skid_inst_q;
                skid_v_d   = pend_q;
                if (pend_q) begin
                    skid_pc_d   = pend_pc_q;
                    skid_inst_d = bus.inst_sram_rdata;
                end
            end else begin
                out_v_d = pend_q;
                if (pend_q) begin
                    out_pc_d   = pend_pc_q;
                    out_inst_d = bus.inst_sram_rdata;
                end
            end
        end else if (pend_q) begin
            skid_v_d    = 1'b1;
            skid_pc_d   = pend_pc_q;
            skid_inst_d = bus.inst_sram_rdata;
        end

        if (sram_en) begin
            pend_d     = 1'b1;
            pend_pc_d  = sram_addr;
            fetch_pc_d = sram_addr + PC_INC;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q  <= RESET_PC;
            pend_q      <= 1'b0;
            pend_pc_q   <= '0;
            out_v_q     <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            skid_v_q    <= 1'b0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            pend_q      <= pend_d;
            pend_pc_q   <= pend_pc_d;
            out_v_q     <= out_v_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            skid_v_q    <= skid_v_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end

    assign bus.inst_sram_en   = sram_en;
    assign bus.inst_sram_addr = sram_addr;
    assign bus.if_valid       = out_v_q;
    assign bus.if_pc          = out_pc_q;
    assign bus.if_inst        = out_inst_q;

endmodule
